// File: rtl/bit_serial_sub_if.sv
// bit_serial_sub_if: start/busy/done handshake and operand/result bus for the bit-serial subtractor
interface bit_serial_sub_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
endinterface

// File: rtl/bit_serial_sub.sv
// bit_serial_sub: one-bit-per-cycle a-b through a single full-subtractor cell with a registered borrow
module bit_serial_sub #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  bit_serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;
  logic             d, bout, last;
  // full-subtractor cell on the current LSBs plus the held borrow
  always_comb begin
    d    = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
    bout = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
    last = cnt_q == CW'(WIDTH - 1);
  end
  // next state: load on accepted start, shift one bit per RUN cycle, publish results on the last bit
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        d_sh_d  = {d, d_sh_q[WIDTH-1:1]};
        bor_d   = bout;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : RUN;
        diff_d  = last ? {d, d_sh_q[WIDTH-1:1]} : diff_q;
        bout_d  = last ? bout : bout_q;
        ovf_d   = last ? (a_msb_q != b_msb_q) && (d != a_msb_q) : ovf_q;
      end
      default: begin
        state_d = bus.start ? RUN : IDLE;
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
        end
      end
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.busy       = state_q == RUN;
  assign bus.done       = state_q == DONE;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;
  assign bus.ovf        = ovf_q;
endmodule
